tick_period_detector: RTL

- Receiving end of the divided-tick interface: watches a single-cycle tick stream produced by the clock divider and recovers its divide setting.
- Measures the clk-cycle interval between successive ticks, checks that it is a power of two, and declares lock after LOCK_COUNT consecutive equal intervals.
- Reports the recovered log2 divide value. Used for self-check of divider configuration and for slaving a second divided domain to an observed tick.

---
 rtl/tick_period_if.sv | 22 ++
 rtl/tick_period_detector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tick_period_if.sv
// tick_period_if -- bundle between a divided-tick source/observer and the
// tick_period_detector.
//   tick_in    : single-cycle tick from the divider
//   clear      : synchronous soft clear (drop lock, back to idle)
//   div_out    : recovered log2 divide
//   locked     : div_out valid and tracking
//   period_err : one-cycle pulse, interval was not a legal power of two
//   timeout    : one-cycle pulse, tick stream stopped
// master drives tick_in/clear, slave (the detector) drives the results.
interface tick_period_if #(
  parameter int CLK_DIV_SIZE = 3
);
  logic                    tick_in;
  logic                    clear;
  logic [CLK_DIV_SIZE-1:0] div_out;
  logic                    locked;
  logic                    period_err;
  logic                    timeout;

  modport master (output tick_in, clear, input div_out, locked, period_err, timeout);
  modport slave  (input tick_in, clear, output div_out, locked, period_err, timeout);
endinterface

// File: rtl/tick_period_detector.sv
// tick_period_detector -- recovers the divide setting of a divided tick stream.
// Measures the clk interval P between accepted ticks, requires P to be a
// power of two no larger than MAX_P = 2^(2^CLK_DIV_SIZE-1), and locks after
// LOCK_COUNT consecutive equal intervals. div_out = log2(P) while locked.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (highest priority)
//   bus  : tick_period_if.slave (tick_in, clear in; div_out, locked,
//          period_err, timeout out -- all outputs registered)
// Build option:
//   TICK_PERIOD_DET_HYST_EN : when defined, lock is only dropped after
//   LOCK_COUNT consecutive non-matching ticks; otherwise one miss drops it.
module tick_period_detector #(
  parameter int CLK_DIV_SIZE = 3,
  parameter int LOCK_COUNT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  tick_period_if.slave        bus
);
  localparam int CW = 2 ** CLK_DIV_SIZE;             // interval counter width
  localparam int MW = $clog2(LOCK_COUNT + 2);        // match/miss counter width
  localparam logic [CW:0]   MAX_P   = {{CW{1'b0}}, 1'b1} << (CW - 1);
  localparam logic [CW:0]   ONE_P   = {{CW{1'b0}}, 1'b1};
  // Counter value at which a missing tick means MAX_P cycles have elapsed.
  localparam logic [CW-1:0] TMO_CNT = {1'b0, {(CW-1){1'b1}}};
  localparam logic [MW-1:0] LC_M    = MW'(LOCK_COUNT);
  localparam logic [MW-1:0] ONE_M   = {{(MW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           counter_q, counter_d;
  logic [MW-1:0]           match_q, match_d;
  logic [CLK_DIV_SIZE-1:0] cand_q, cand_d;
  logic [CLK_DIV_SIZE-1:0] div_q, div_d;
  logic                    locked_q, locked_d;
  logic                    perr_q, perr_d;
  logic                    tmo_q, tmo_d;
`ifdef TICK_PERIOD_DET_HYST_EN
  logic [MW-1:0]           miss_q, miss_d;
`endif

  logic [CW:0]             p;
  logic                    p_legal;
  logic [CLK_DIV_SIZE-1:0] d;
  logic                    drop;

  always_comb begin
    p       = {1'b0, counter_q} + ONE_P;
    p_legal = (p != '0) && ((p & (p - ONE_P)) == '0) && (p <= MAX_P);
    d       = '0;
    for (int i = 0; i < CW; i++)
      if (p[i]) d = CLK_DIV_SIZE'(i);
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    match_d   = match_q;
    cand_d    = cand_q;
    div_d     = div_q;
    perr_d    = 1'b0;
    tmo_d     = 1'b0;
    drop      = 1'b0;
`ifdef TICK_PERIOD_DET_HYST_EN
    miss_d    = miss_q;
`endif
    if (bus.clear) begin
      // Same as reset except div_out keeps the last recovered value.
      state_d   = IDLE;
      counter_d = '0;
      match_d   = '0;
`ifdef TICK_PERIOD_DET_HYST_EN
      miss_d    = '0;
`endif
    end else if (state_q == IDLE) begin
      counter_d = '0;
      if (bus.tick_in) state_d = MEASURE;    // first edge, no interval yet
    end else if (bus.tick_in) begin
      counter_d = '0;
      case (state_q)
        MEASURE: begin
          if (p_legal) begin
            cand_d  = d;
            match_d = ONE_M;
            if (LOCK_COUNT == 1) begin
              state_d = LOCKED;
              div_d   = d;
            end else begin
              state_d = CHECK;
            end
          end else begin
            perr_d = 1'b1;
          end
        end
        CHECK: begin
          if (!p_legal) begin
            perr_d  = 1'b1;
            match_d = '0;
            state_d = MEASURE;
          end else if (d == cand_q) begin
            match_d = match_q + ONE_M;
            if (match_d >= LC_M) begin
              state_d = LOCKED;
              div_d   = cand_q;
            end
          end else begin
            cand_d  = d;
            match_d = ONE_M;
          end
        end
        LOCKED: begin
          if (p_legal && d == div_q) begin
`ifdef TICK_PERIOD_DET_HYST_EN
            miss_d = '0;
`endif
          end else begin
            perr_d = !p_legal;
`ifdef TICK_PERIOD_DET_HYST_EN
            miss_d = miss_q + ONE_M;
            drop   = (miss_d >= LC_M);
`else
            drop   = 1'b1;
`endif
          end
          if (drop) begin
`ifdef TICK_PERIOD_DET_HYST_EN
            miss_d = '0;
`endif
            // The interval that caused the drop seeds the next lock attempt.
            if (p_legal) begin
              state_d = CHECK;
              cand_d  = d;
              match_d = ONE_M;
            end else begin
              state_d = MEASURE;
              match_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (counter_q == TMO_CNT) begin
      // A tick now would have been P = MAX_P; none came, so give up.
      tmo_d     = 1'b1;
      state_d   = IDLE;
      counter_d = '0;
      match_d   = '0;
`ifdef TICK_PERIOD_DET_HYST_EN
      miss_d    = '0;
`endif
    end else begin
      counter_d = counter_q + CW'(1);
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      match_q   <= '0;
      cand_q    <= '0;
      div_q     <= '0;
      locked_q  <= 1'b0;
      perr_q    <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef TICK_PERIOD_DET_HYST_EN
      miss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      match_q   <= match_d;
      cand_q    <= cand_d;
      div_q     <= div_d;
      locked_q  <= locked_d;
      perr_q    <= perr_d;
      tmo_q     <= tmo_d;
`ifdef TICK_PERIOD_DET_HYST_EN
      miss_q    <= miss_d;
`endif
    end
  end

  assign bus.div_out    = div_q;
  assign bus.locked     = locked_q;
  assign bus.period_err = perr_q;
  assign bus.timeout    = tmo_q;
endmodule
